// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop pin synchroniser, mid-cell sampling from a baud divider,
// rx_end for good frames, rx_frame_err for a low stop bit, and a BRK state that waits out stuck-low lines.
module uart_rx #(
  parameter int BAUD_DIV = 260
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_busy,
  output logic       rx_end,
  output logic [7:0] rx_data,
  output logic       rx_frame_err
);

  localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t      state, state_nx;
  logic        rx_p0, rx_sync_p1;
  logic [15:0] div_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_q;
  logic        half_hit, full_hit;
  logic        shift_en, load_en, err_en, cnt_clr;

  assign half_hit = (div_cnt == HALF_M1);
  assign full_hit = (div_cnt == FULL_M1);
  assign rx_busy  = (state != IDLE);

  always_comb begin
    state_nx = state;
    shift_en = 1'b0;
    load_en  = 1'b0;
    err_en   = 1'b0;
    case (state)
      IDLE:  if (!rx_sync_p1) state_nx = START;
      START: if (half_hit) state_nx = rx_sync_p1 ? IDLE : DATA;
      DATA: begin
        if (full_hit) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (full_hit) begin
          if (rx_sync_p1) begin
            load_en  = 1'b1;
            state_nx = IDLE;
          end else begin
            err_en   = 1'b1;
            state_nx = BRK;
          end
        end
      end
      BRK:     if (rx_sync_p1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // The divider restarts on every state change and every data sample, and rests at 0 in IDLE.
    cnt_clr = (state_nx != state) || shift_en || (state == IDLE);
  end

  // Stage p0/p1: pin synchroniser
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0      <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_p0      <= rx;
      rx_sync_p1 <= rx_p0;
    end
  end

  // Frame state, divider and shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
    end else begin
      state   <= state_nx;
      div_cnt <= cnt_clr ? 16'd0 : div_cnt + 16'd1;
      if (shift_en) begin
        shift_q <= {rx_sync_p1, shift_q[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end else if (state != DATA) begin
        bit_cnt <= '0;
      end
    end
  end

  // Registered outputs, updated at the stop-bit sample edge
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data      <= '0;
      rx_end       <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_end       <= load_en;
      rx_frame_err <= err_en;
      if (load_en) rx_data <= shift_q;
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver feeding the UART control/register block: drives its rx_busy, rx_end and rx_data inputs.
- Deserialises 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) from the asynchronous rx pin.
- Uses a clock divider to sample each bit mid-cell, plus a 2-flop synchroniser on the pin.
- Stop-bit failures are reported on a separate pulse and do not produce rx_end, so the control block never latches a corrupt byte.

Parameters:
- BAUD_DIV, 260, clk cycles per bit cell. Legal range 4..65535. Half-bit count is BAUD_DIV/2, integer divide.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx  in  1  asynchronous serial input, idle high
- rx_busy  out  1  frame reception in progress
- rx_end  out  1  one-cycle pulse: valid byte received, rx_data updated this cycle
- rx_data  out  8  last correctly framed byte, held until the next valid frame
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. All actions occur on posedge clk.
  - State = IDLE.
  - Both synchroniser flops = 1.
  - div_cnt = 0, bit_cnt = 0, shift register = 0.
  - Outputs: rx_data = 0x00, rx_end = 0, rx_frame_err = 0, rx_busy = 0.
- Synchroniser: rx passes through two flops to give rx_sync. All decisions use rx_sync only, giving 2 cycles of added latency.
- rx_busy = (state != IDLE), decoded directly from the state register.
- div_cnt is 16 bits. It is cleared on every state entry and on every bit sample.
- State machine:
  - IDLE: when rx_sync == 0, go to START (div_cnt = 0).
  - START: count until div_cnt == BAUD_DIV/2 - 1, then sample rx_sync.
    - Sample 0: go to DATA, bit_cnt = 0.
    - Sample 1: false start; go to IDLE with no pulse.
  - DATA: when div_cnt == BAUD_DIV - 1, shift right with rx_sync entering at bit 7, and increment bit_cnt.
    - After the 8th sample (bit_cnt was 7), go to STOP.
  - STOP: when div_cnt == BAUD_DIV - 1, sample rx_sync.
    - Sample 1: rx_data <= shift register, rx_end = 1 for one cycle, go to IDLE.
    - Sample 0: rx_frame_err = 1 for one cycle, rx_data unchanged, no rx_end, go to BRK.
  - BRK: wait until rx_sync == 1, then go to IDLE. This prevents a break or stuck-low line from retriggering reception.
- Pulse timing: rx_end and rx_frame_err are registered. They are high exactly one cycle, starting at the edge that samples the stop bit. rx_data changes on that same edge.
- Pulse exclusivity: rx_end and rx_frame_err are never high together. No output pulses repeat without a new frame.
- Latency: rx_end rises 2 + BAUD_DIV/2 + 9*BAUD_DIV (±1) cycles after the rx falling edge of the start bit.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start bit immediately following the stop bit is accepted with no lost frame.
- Pin activity while busy: ignored except at the sample points (no oversampling vote).
- Reset mid-frame: the frame is abandoned, all reset values are applied, and no pulse is emitted. The next falling edge after reset starts a fresh frame.
- The rx pin is never sampled without the synchroniser; no combinational path from rx to any output.

Test Plan:
- BAUD_DIV=16, send 0xA5 → rx_busy high from ~3 cycles after the start edge; rx_end one-cycle pulse 154±1 cycles after the start edge; rx_data = 0xA5; rx_frame_err stays 0; rx_busy drops after the pulse.
- Send 0x00 then 0xFF back-to-back (new start bit immediately after the stop bit) → two rx_end pulses 160 cycles apart; rx_data = 0x00 then 0xFF.
- Low glitch of 5 cycles (less than BAUD_DIV/2 = 8) on an idle line → rx_busy high for at most 10 cycles then 0; no rx_end, no rx_frame_err; rx_data unchanged.
- Send 0x3C with the stop bit forced 0, line held low 40 further cycles, then high → rx_frame_err single pulse; rx_end never asserted; rx_data keeps prior value 0xA5; rx_busy stays 1 until 2-3 cycles after the line returns high.
- Assert reset for 1 cycle midway through the data bits of 0x5A → next cycle rx_busy = 0 and rx_data = 0x00; the remainder of the aborted frame produces no rx_end; a following 0x81 frame is received correctly.
- BAUD_DIV=16, transmitter bit period 17 cycles (~6% slow), send 0x96 → rx_data = 0x96, rx_end asserted, no frame error.
